// File: rtl/score_bcd_accumulator_if.sv
// Event and score bundle between the game logic and score_bcd_accumulator.
// The master drives events and restart; the slave returns the committed score and status.
interface score_bcd_accumulator_if;
    logic        clear;
    logic        pellet_evt;
    logic        power_evt;
    logic        ghost_evt;
    logic [15:0] score;
    logic        score_upd;
    logic        busy;
    logic        evt_lost;

    modport master (
        output clear, pellet_evt, power_evt, ghost_evt,
        input  score, score_upd, busy, evt_lost
    );

    modport slave (
        input  clear, pellet_evt, power_evt, ghost_evt,
        output score, score_upd, busy, evt_lost
    );
endinterface

// File: rtl/score_bcd_accumulator.sv
// Queues pellet/power/ghost events and adds them digit-serially into a 4-digit packed-BCD score.
// Define SCORE_SAT_EN to saturate at 9999 on overflow; otherwise the score wraps modulo 10000.
module score_bcd_accumulator #(
    parameter int PEND_W = 3
) (
    input  logic                   board_clk,
    input  logic                   Reset,
    score_bcd_accumulator_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, COMMIT = 2'd2} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       PEL_ADD  = 16'h0010;
    localparam logic [15:0]       POW_ADD  = 16'h0050;

    state_t            state;
    logic [PEND_W-1:0] p_pel, p_pow, p_gho;
    logic [1:0]        gidx;
    logic [1:0]        dig;
    logic [15:0]       work;
    logic [15:0]       addend;
    logic [15:0]       score_r;
    logic              carry;
    logic              score_upd_r;
    logic              evt_lost_r;

    logic              ld_gho, ld_pow, ld_pel, ld_any;
    logic [PEND_W:0]   nxt_pel, nxt_pow, nxt_gho;
    logic [3:0]        work_dig, add_dig;
    logic [4:0]        dsum;

    // Returns {lost, next_count}. A saturated increment is always dropped, even alongside a consume.
    function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [PEND_W:0] r;
        r = {1'b0, cnt};
        if (inc && (cnt == PEND_MAX)) begin
            r = dec ? {1'b1, cnt - PEND_ONE} : {1'b1, cnt};
        end else if (inc && !dec) begin
            r = {1'b0, cnt + PEND_ONE};
        end else if (dec && !inc) begin
            r = {1'b0, cnt - PEND_ONE};
        end
        return r;
    endfunction

    // Returns {carry_out, digit}; the digit is always 0..9.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic cin);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        t = s - 5'd10;
        if (s > 5'd9) s = {1'b1, t[3:0]};
        return s;
    endfunction

    function automatic logic [15:0] ghost_addend(input logic [1:0] g);
        case (g)
            2'd0:    return 16'h0200;
            2'd1:    return 16'h0400;
            2'd2:    return 16'h0800;
            default: return 16'h1600;
        endcase
    endfunction

`ifdef SCORE_SAT_EN
    function automatic logic [15:0] saturate_score(input logic [15:0] w, input logic c);
        return c ? 16'h9999 : w;
    endfunction
`endif

    // The cycle right after a commit (score_upd high) never loads, giving one add per 7 cycles.
    always_comb begin
        ld_gho   = (state == IDLE) && !score_upd_r && (p_gho != '0);
        ld_pow   = (state == IDLE) && !score_upd_r && (p_gho == '0) && (p_pow != '0);
        ld_pel   = (state == IDLE) && !score_upd_r && (p_gho == '0) && (p_pow == '0) &&
                   (p_pel != '0);
        ld_any   = ld_gho | ld_pow | ld_pel;
        nxt_pel  = pend_next(p_pel, bus.pellet_evt, ld_pel);
        nxt_pow  = pend_next(p_pow, bus.power_evt, ld_pow);
        nxt_gho  = pend_next(p_gho, bus.ghost_evt, ld_gho);
        work_dig = work[{dig, 2'b00} +: 4];
        add_dig  = addend[{dig, 2'b00} +: 4];
        dsum     = bcd_digit_add(work_dig, add_dig, carry);
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            p_pel       <= '0;
            p_pow       <= '0;
            p_gho       <= '0;
            gidx        <= 2'd0;
            dig         <= 2'd0;
            work        <= 16'h0000;
            addend      <= 16'h0000;
            score_r     <= 16'h0000;
            carry       <= 1'b0;
            score_upd_r <= 1'b0;
            evt_lost_r  <= 1'b0;
        end else if (bus.clear) begin
            state       <= IDLE;
            p_pel       <= '0;
            p_pow       <= '0;
            p_gho       <= '0;
            gidx        <= 2'd0;
            dig         <= 2'd0;
            work        <= 16'h0000;
            addend      <= 16'h0000;
            score_r     <= 16'h0000;
            carry       <= 1'b0;
            score_upd_r <= 1'b0;
            evt_lost_r  <= 1'b0;
        end else begin
            p_pel       <= nxt_pel[PEND_W-1:0];
            p_pow       <= nxt_pow[PEND_W-1:0];
            p_gho       <= nxt_gho[PEND_W-1:0];
            evt_lost_r  <= evt_lost_r | nxt_pel[PEND_W] | nxt_pow[PEND_W] | nxt_gho[PEND_W];
            score_upd_r <= 1'b0;

            // A coincident power event wins over the ghost-load increment; the load still used old gidx.
            if (bus.power_evt) begin
                gidx <= 2'd0;
            end else if (ld_gho && (gidx != 2'd3)) begin
                gidx <= gidx + 2'd1;
            end

            case (state)
                IDLE: begin
                    if (ld_any) begin
                        addend <= ld_gho ? ghost_addend(gidx) : (ld_pow ? POW_ADD : PEL_ADD);
                        work   <= score_r;
                        carry  <= 1'b0;
                        dig    <= 2'd0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    work[{dig, 2'b00} +: 4] <= dsum[3:0];
                    carry                   <= dsum[4];
                    if (dig == 2'd3) begin
                        state <= COMMIT;
                    end else begin
                        dig <= dig + 2'd1;
                    end
                end
                COMMIT: begin
`ifdef SCORE_SAT_EN
                    score_r <= saturate_score(work, carry);
`else
                    score_r <= work;
`endif
                    score_upd_r <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.score     = score_r;
    assign bus.score_upd = score_upd_r;
    assign bus.evt_lost  = evt_lost_r;
    assign bus.busy      = (state != IDLE) || (p_pel != '0) || (p_pow != '0) || (p_gho != '0);

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Self-checking bench for score_bcd_accumulator: a table of event vectors, hand-written
// timing/overflow/abort sequences, and a queue of expected committed scores.
module tb_score_bcd_accumulator;

    logic board_clk = 1'b0;
    logic Reset     = 1'b1;

    score_bcd_accumulator_if bus();

    score_bcd_accumulator #(.PEND_W(3)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 board_clk = ~board_clk;

    typedef struct {
        logic        pel;
        logic        pow;
        logic        gho;
        logic [15:0] exp_score;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] exp_q [$];
    logic [15:0] m_score = 16'h0000;
    int          m_gidx  = 0;
    int          tests   = 0;
    int          fails   = 0;

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t;
        r = 16'h0000;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] model_add(input logic [15:0] s, input logic [15:0] a);
        int v;
        v = bcd2int(s) + bcd2int(a);
`ifdef SCORE_SAT_EN
        if (v > 9999) v = 9999;
`else
        v = v % 10000;
`endif
        return int2bcd(v);
    endfunction

    function automatic logic [15:0] ghost_value(input int g);
        case (g)
            0:       return 16'h0200;
            1:       return 16'h0400;
            2:       return 16'h0800;
            default: return 16'h1600;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Every score_upd pulse must match the oldest outstanding expectation.
    always @(negedge board_clk) begin
        if (bus.score_upd === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: score_upd with score %h, required no update", bus.score);
            end else begin
                check("commit_score", {16'h0, bus.score}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_exp(input logic [15:0] a);
        m_score = model_add(m_score, a);
        exp_q.push_back(m_score);
    endtask

    task automatic push_evt(input logic pel, input logic pow, input logic gho);
        if (pow) m_gidx = 0;
        if (gho) begin
            push_exp(ghost_value(m_gidx));
            if (m_gidx < 3) m_gidx++;
        end
        if (pow) push_exp(16'h0050);
        if (pel) push_exp(16'h0010);
    endtask

    task automatic drive_evt(input logic pel, input logic pow, input logic gho);
        @(negedge board_clk);
        bus.pellet_evt = pel;
        bus.power_evt  = pow;
        bus.ghost_evt  = gho;
        push_evt(pel, pow, gho);
        @(negedge board_clk);
        bus.pellet_evt = 1'b0;
        bus.power_evt  = 1'b0;
        bus.ghost_evt  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge board_clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, bus.busy, n);
        end
        @(negedge board_clk);
    endtask

    task automatic do_clear();
        @(negedge board_clk);
        bus.clear = 1'b1;
        @(negedge board_clk);
        bus.clear = 1'b0;
        m_score = 16'h0000;
        m_gidx  = 0;
        exp_q.delete();
    endtask

    task automatic preload_pellets(input int n);
        for (int i = 0; i < n; i++) begin
            drive_evt(1'b1, 1'b0, 1'b0);
            wait_idle("preload");
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int ups [3];
        int nup;

        bus.clear      = 1'b0;
        bus.pellet_evt = 1'b0;
        bus.power_evt  = 1'b0;
        bus.ghost_evt  = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0020};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0070};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0270};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0670};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h1480};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h3080};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h3330};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 16'h3590};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 16'h3650};

        repeat (3) @(negedge board_clk);
        check("reset_score", {16'h0, bus.score}, 32'h0);
        check("reset_score_upd", {31'h0, bus.score_upd}, 32'h0);
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_evt_lost", {31'h0, bus.evt_lost}, 32'h0);
        Reset = 1'b0;
        repeat (2) @(negedge board_clk);

        for (int i = 0; i < 10; i++) begin
            drive_evt(vecs[i].pel, vecs[i].pow, vecs[i].gho);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_score", i), {16'h0, bus.score}, {16'h0, vecs[i].exp_score});
            check($sformatf("vec%0d_evt_lost", i), {31'h0, bus.evt_lost}, 32'h0);
        end

        // Power then five ghosts: the chain saturates at 1600.
        do_clear();
        check("clear_score", {16'h0, bus.score}, 32'h0);
        drive_evt(1'b0, 1'b1, 1'b0);
        wait_idle("chain_pow");
        for (int g = 0; g < 5; g++) begin
            drive_evt(1'b0, 1'b0, 1'b1);
            wait_idle("chain_gho");
        end
        check("ghost_chain_score", {16'h0, bus.score}, 32'h4650);

        // Three pellets 20 cycles apart: score_upd seen 7 cycles after each event edge.
        do_clear();
        for (int r = 0; r < 3; r++) begin
            @(negedge board_clk);
            bus.pellet_evt = 1'b1;
            push_evt(1'b1, 1'b0, 1'b0);
            @(negedge board_clk);
            bus.pellet_evt = 1'b0;
            cnt = 1;
            check("pellet_busy_rise", {31'h0, bus.busy}, 32'h1);
            while (bus.score_upd !== 1'b1 && cnt < 20) begin
                @(negedge board_clk);
                cnt++;
            end
            check("pellet_latency", cnt, 32'd7);
            repeat (13) @(negedge board_clk);
        end
        check("pellet_triple_score", {16'h0, bus.score}, 32'h0030);

        // All three event types on one edge: commits 7 cycles apart, ghost first.
        do_clear();
        @(negedge board_clk);
        bus.pellet_evt = 1'b1;
        bus.power_evt  = 1'b1;
        bus.ghost_evt  = 1'b1;
        push_evt(1'b1, 1'b1, 1'b1);
        @(negedge board_clk);
        bus.pellet_evt = 1'b0;
        bus.power_evt  = 1'b0;
        bus.ghost_evt  = 1'b0;
        nup = 0;
        ups[0] = 0;
        ups[1] = 0;
        ups[2] = 0;
        for (int c = 1; c <= 25; c++) begin
            if (bus.score_upd === 1'b1 && nup < 3) begin
                ups[nup] = c;
                nup++;
            end
            if (c == 20) check("simul_busy_before_last", {31'h0, bus.busy}, 32'h1);
            if (c == 21) check("simul_busy_after_last", {31'h0, bus.busy}, 32'h0);
            @(negedge board_clk);
        end
        check("simul_commit0_time", ups[0], 32'd7);
        check("simul_commit1_time", ups[1], 32'd14);
        check("simul_commit2_time", ups[2], 32'd21);
        check("simul_score", {16'h0, bus.score}, 32'h0260);

        // Power event on the very edge a ghost is loaded: load keeps old gidx, then chain restarts.
        do_clear();
        drive_evt(1'b0, 1'b1, 1'b0);
        wait_idle("coin_pow");
        drive_evt(1'b0, 1'b0, 1'b1);
        wait_idle("coin_g0");
        drive_evt(1'b0, 1'b0, 1'b1);
        wait_idle("coin_g1");
        @(negedge board_clk);
        bus.ghost_evt = 1'b1;
        @(negedge board_clk);
        bus.ghost_evt = 1'b0;
        bus.power_evt = 1'b1;
        push_exp(16'h0800);
        push_exp(16'h0050);
        m_gidx = 0;
        @(negedge board_clk);
        bus.power_evt = 1'b0;
        wait_idle("coin_load");
        drive_evt(1'b0, 1'b0, 1'b1);
        wait_idle("coin_after");
        check("coincident_power_score", {16'h0, bus.score}, 32'h1700);

        // Nine back-to-back pellets: the ninth hits a saturated counter and is lost.
        do_clear();
        @(negedge board_clk);
        bus.pellet_evt = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) push_exp(16'h0010);
            @(negedge board_clk);
        end
        bus.pellet_evt = 1'b0;
        check("burst_busy", {31'h0, bus.busy}, 32'h1);
        wait_idle("burst");
        check("burst_score", {16'h0, bus.score}, 32'h0080);
        check("burst_evt_lost", {31'h0, bus.evt_lost}, 32'h1);
        do_clear();
        check("clear_evt_lost", {31'h0, bus.evt_lost}, 32'h0);

        // Overflow past 9999.
        preload_pellets(999);
        check("preload_9990", {16'h0, bus.score}, 32'h9990);
        drive_evt(1'b1, 1'b0, 1'b0);
        wait_idle("overflow");
`ifdef SCORE_SAT_EN
        check("overflow_score", {16'h0, bus.score}, 32'h9999);
`else
        check("overflow_score", {16'h0, bus.score}, 32'h0000);
`endif

        // Synchronous clear at E+3 of a ghost add: no commit, everything idle.
        do_clear();
        preload_pellets(12);
        check("preload_0120", {16'h0, bus.score}, 32'h0120);
        @(negedge board_clk);
        bus.ghost_evt = 1'b1;
        @(negedge board_clk);
        bus.ghost_evt = 1'b0;
        repeat (2) @(negedge board_clk);
        bus.clear = 1'b1;
        @(negedge board_clk);
        bus.clear = 1'b0;
        m_score = 16'h0000;
        m_gidx  = 0;
        check("abort_clear_score", {16'h0, bus.score}, 32'h0);
        check("abort_clear_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_clear_upd", {31'h0, bus.score_upd}, 32'h0);
        repeat (10) @(negedge board_clk);
        check("abort_clear_score_later", {16'h0, bus.score}, 32'h0);

        // Asynchronous Reset mid-ADD acts before the next clock edge.
        preload_pellets(12);
        check("preload2_0120", {16'h0, bus.score}, 32'h0120);
        @(negedge board_clk);
        bus.ghost_evt = 1'b1;
        @(negedge board_clk);
        bus.ghost_evt = 1'b0;
        repeat (2) @(negedge board_clk);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_score", {16'h0, bus.score}, 32'h0);
        check("async_reset_busy", {31'h0, bus.busy}, 32'h0);
        check("async_reset_upd", {31'h0, bus.score_upd}, 32'h0);
        m_score = 16'h0000;
        m_gidx  = 0;
        @(negedge board_clk);
        Reset = 1'b0;
        repeat (10) @(negedge board_clk);
        check("async_reset_score_later", {16'h0, bus.score}, 32'h0);
        check("async_reset_busy_later", {31'h0, bus.busy}, 32'h0);

        check("pending_expectations", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_bcd_accumulator.md
# score_bcd_accumulator

Converts single-cycle game events (pellet eaten, power pellet eaten, ghost eaten) into a 4-digit packed-BCD score that drives the top-level seven-segment score digits directly. It sits downstream of `pacman_movement` and the ghost collision logic, and upstream of the SSD scan mux. Events are queued per type, then added digit-serially. The score register changes atomically, so the display never shows a partial sum.

## Interface
- `PEND_W`, default 3: width of each per-type pending-event counter.

- `board_clk` in 1: system clock, 100 MHz.
- `Reset` in 1: asynchronous, active-high. Clears all state.
- `clear` in 1: synchronous game restart. Same effect as `Reset`, applied on the clock edge.
- `pellet_evt` in 1: one-cycle pulse. Adds 10.
- `power_evt` in 1: one-cycle pulse. Adds 50 and restarts the ghost chain.
- `ghost_evt` in 1: one-cycle pulse. Adds 200/400/800/1600 according to the chain position.
- `score` out 16: packed BCD, [15:12] thousands through [3:0] units.
- `score_upd` out 1: one-cycle pulse, high the cycle after `score` changes.
- `busy` out 1: high when not in IDLE or when any pending counter is nonzero.
- `evt_lost` out 1: sticky. Set when an event arrives while its counter is saturated.

Reset value of every output is 0.

## Operation
**Pending counters**
- Three counters, `p_pel`, `p_pow` and `p_gho`, each `PEND_W` bits wide.
- Each counter increments on its event pulse and saturates at 2^PEND_W−1.
- An increment that arrives while the counter is saturated is dropped and sets `evt_lost`.
- If an increment and a consume hit the same counter in the same cycle, the count is unchanged.

**Ghost chain**
- 2-bit `gidx`.
- Cleared when `power_evt` is sampled.
- After each ghost addend is loaded, `gidx` increments, saturating at 3.
- Addend by `gidx`: 0 → 0x0200, 1 → 0x0400, 2 → 0x0800, 3 → 0x1600.
- If `power_evt` and a ghost load occur in the same cycle, the load uses the old `gidx`, then the clear takes effect.

**FSM: IDLE → ADD → COMMIT → IDLE**
- IDLE:
  - If any counter is nonzero, select one by priority: ghost > power > pellet.
  - Latch its BCD addend (pellet 0x0010, power 0x0050) and decrement that counter.
  - Copy `score` into working register `work`, clear `carry`, set `dig` = 0, go to ADD.
- ADD: one digit per cycle, `dig` = 0..3.
  - Compute s = work[dig] + addend[dig] + carry.
  - If s > 9: work[dig] = s−10 and carry = 1. Otherwise work[dig] = s and carry = 0.
  - After `dig` = 3, go to COMMIT.
- COMMIT:
  - If the final carry is 1, apply the overflow rule (see Configuration).
  - Write `score` ← `work`, pulse `score_upd`, return to IDLE.

**Clear and reset mid-operation**
- `clear` or `Reset` aborts any in-flight add with no partial write.
- Zeroes `score`, all counters, `gidx` and `evt_lost`, and sends the FSM to IDLE.
- Event pulses coincident with `clear` are discarded.

**Arithmetic rules**
- Digits never hold values above 9.
- `score` only ever holds a committed, valid BCD value.

## Timing
- Event sampled at edge E:
  - Pending counter updates at E.
  - Load happens at E+1.
  - Digits 0..3 are added at E+2..E+5.
  - COMMIT writes `score` at E+6.
  - `score_upd` is high during the cycle following E+6.
- Latency: 6 cycles per event.
- Sustained throughput: one event per 7 cycles, since IDLE consumes one cycle between adds.
- Simultaneous pulses of all three types at edge E:
  - Ghost commits at E+6, power at E+13, pellet at E+20.
- `busy` goes high the cycle after E and falls the cycle after the last COMMIT.
- `Reset` acts immediately on assertion, independent of `board_clk`.

## Configuration
- `SCORE_SAT_EN` defined: overflow past 9999 saturates. COMMIT writes 0x9999 whenever the final carry is 1; `score_upd` still pulses.
- `SCORE_SAT_EN` undefined: overflow wraps modulo 10000. The carry is discarded and the low four digits are written.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then 3 `pellet_evt` pulses 20 cycles apart → `score` = 0x0030; 3 `score_upd` pulses; each pulse 7 cycles after its event edge.
- `power_evt`, then 5 `ghost_evt` (spaced) → `score` = 0x0050 + 0x0200 + 0x0400 + 0x0800 + 0x1600 + 0x1600 = 0x4650.
- `pellet_evt`, `power_evt` and `ghost_evt` in the same cycle from 0 → commits in order 0x0200, 0x0250, 0x0260 at E+6, E+13, E+20; `busy` falls after E+20.
- Preload to 0x9990 via pellets, then 1 pellet → 0x0000 without `SCORE_SAT_EN`; 0x9999 with it defined.
- 9 back-to-back `pellet_evt` on consecutive cycles (PEND_W = 3) → `evt_lost` = 1; final `score` = 0x0080 (first event consumed at load, then 7 queued; 1 dropped).
- `clear` asserted at E+3 of a ghost add from 0x0120 → `score` = 0x0000, no `score_upd`, `busy` = 0 the next cycle; async `Reset` mid-ADD → same result.
